// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential cache reads,
// buffers {instruction, pc} pairs in a small FIFO and flushes on redirect.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int INSN_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      entry,
  output logic                       instruction_read,
  output logic [ADDR_WIDTH-1:0]      instruction_address,
  input  logic                       instruction_busy,
  input  logic [INSN_WIDTH-1:0]      instruction_response,
  input  logic                       redirect,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       out_valid,
  output logic [INSN_WIDTH-1:0]      out_instruction,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count, count_next;
  logic                  push, pop, flush;

  logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  // Redirect outranks both push and pop; the response of that cycle is dropped.
  always_comb begin
    flush            = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    out_valid        = 1'b0;
    instruction_read = 1'b0;
    count_next       = count;
    state_next       = state;
    pc_next          = pc;

    flush            = redirect && (state != IDLE);
    instruction_read = (state == FETCH);
    push             = (state == FETCH) && !instruction_busy && !redirect;
    out_valid        = (count != '0) && !redirect;
    pop              = out_valid && out_ready;

    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    case (state)
      IDLE: begin
        pc_next    = entry;
        state_next = FETCH;
      end
      FETCH: begin
        if (push) pc_next = pc + ADDR_WIDTH'(4);
        if (count_next == FULL_COUNT) state_next = FULL;
      end
      FULL: begin
        if (pop) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      count_next = '0;
      pc_next    = redirect_pc;
      state_next = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (pop)  head <= head + PW'(1);
        if (push) tail <= tail + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head outputs read as zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      insn_mem[tail] <= instruction_response;
      pc_mem[tail]   <= pc;
    end
  end

  assign instruction_address = pc;
  assign out_instruction     = insn_mem[head];
  assign out_pc              = pc_mem[head];
  assign occupancy           = count;

  no_push_when_full: assert property (
    @(posedge clk) disable iff (reset) !(push && (count == FULL_COUNT))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard of expected head PCs is filled by
// the stimulus and drained by a negedge monitor on every accepted pop.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     entry;
  logic              instruction_read;
  logic [AW-1:0]     instruction_address;
  logic              instruction_busy;
  logic [IW-1:0]     instruction_response;
  logic              redirect;
  logic [AW-1:0]     redirect_pc;
  logic              out_valid;
  logic [IW-1:0]     out_instruction;
  logic [AW-1:0]     out_pc;
  logic              out_ready;
  logic [$clog2(DEPTH):0] occupancy;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] insn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSN_WIDTH(IW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .entry               (entry),
    .instruction_read    (instruction_read),
    .instruction_address (instruction_address),
    .instruction_busy    (instruction_busy),
    .instruction_response(instruction_response),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_instruction     (out_instruction),
    .out_pc              (out_pc),
    .out_ready           (out_ready),
    .occupancy           (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] insn_of(input logic [AW-1:0] a);
    return a[IW-1:0] ^ 32'h5A5A_0000;
  endfunction

  // Cache model: data is a fixed scramble of the requested address.
  always_comb instruction_response = instruction_read ? insn_of(instruction_address) : '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic busy, input logic ready,
                               input logic redir = 1'b0, input logic [AW-1:0] rpc = '0);
    instruction_busy = busy;
    out_ready        = ready;
    redirect         = redir;
    redirect_pc      = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [AW-1:0] p);
    exp_t e;
    e.pc   = p;
    e.insn = insn_of(p);
    sb.push_back(e);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    sb.delete();
    tick();
    tick();
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got pc 0x%0h, expected no entry", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("pop_pc", out_pc, e.pc);
        checkOutput("pop_insn", 64'(out_instruction), 64'(e.insn));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    entry = 64'h1000;
    applyStimulus(1'b0, 1'b0);

    // Reset state and steady stream
    hold_reset();
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);
    checkOutput("rst_read", 64'(instruction_read), 64'd0);
    checkOutput("rst_addr", instruction_address, 64'd0);
    checkOutput("rst_out_pc", out_pc, 64'd0);
    for (int i = 0; i < 8; i++) expect_pc(64'h1000 + 64'(4 * i));
    applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
    tick();
    checkOutput("stream_first_addr", instruction_address, 64'h1000);
    checkOutput("stream_first_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("stream_addr", instruction_address, 64'h1004 + 64'(4 * i));
      checkOutput("stream_occ", 64'(occupancy), 64'd1);
    end
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("stream_drain_occ", 64'(occupancy), 64'd0);
    checkOutput("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure to full, then drain with push+pop at DEPTH-1
    hold_reset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    repeat (4) tick();
    checkOutput("full_occ", 64'(occupancy), 64'd4);
    checkOutput("full_read", 64'(instruction_read), 64'd0);
    checkOutput("full_addr", instruction_address, 64'h1010);
    tick();
    checkOutput("full_hold_occ", 64'(occupancy), 64'd4);
    checkOutput("full_hold_read", 64'(instruction_read), 64'd0);
    for (int i = 0; i < 5; i++) expect_pc(64'h1000 + 64'(4 * i));
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("unfull_occ", 64'(occupancy), 64'd3);
    checkOutput("unfull_read", 64'(instruction_read), 64'd1);
    checkOutput("unfull_addr", instruction_address, 64'h1010);
    tick();
    checkOutput("pushpop_occ", 64'(occupancy), 64'd3);
    checkOutput("pushpop_read", 64'(instruction_read), 64'd1);
    checkOutput("pushpop_addr", instruction_address, 64'h1014);
    applyStimulus(1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("bp_drain_occ", 64'(occupancy), 64'd0);
    checkOutput("bp_sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("bp_busy_addr", instruction_address, 64'h1014);

    // Cache busy holds the PC without pushing
    hold_reset();
    reset = 1'b0;
    expect_pc(64'h1000);
    expect_pc(64'h1004);
    expect_pc(64'h1008);
    applyStimulus(1'b0, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("busy_addr", instruction_address, 64'h1008);
      checkOutput("busy_read", 64'(instruction_read), 64'd1);
    end
    checkOutput("busy_occ", 64'(occupancy), 64'd0);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("unbusy_occ", 64'(occupancy), 64'd1);
    checkOutput("unbusy_addr", instruction_address, 64'h100C);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("busy_sb_empty", 64'(sb.size()), 64'd0);

    // Redirect with a partially filled FIFO, then back-to-back redirects
    hold_reset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("pre_redir_occ", 64'(occupancy), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h2000);
    #1;
    checkOutput("redir_valid", 64'(out_valid), 64'd0);
    tick();
    expect_pc(64'h2000);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("post_redir_occ", 64'(occupancy), 64'd0);
    checkOutput("post_redir_addr", instruction_address, 64'h2000);
    checkOutput("post_redir_valid", 64'(out_valid), 64'd0);
    tick();
    checkOutput("redir_push_occ", 64'(occupancy), 64'd1);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("redir_sb_empty", 64'(sb.size()), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h3000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h4000);
    tick();
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("b2b_addr", instruction_address, 64'h4000);
    checkOutput("b2b_occ", 64'(occupancy), 64'd0);
    checkOutput("b2b_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with two entries buffered
    hold_reset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("pre_areset_occ", 64'(occupancy), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_valid", 64'(out_valid), 64'd0);
    checkOutput("areset_occ", 64'(occupancy), 64'd0);
    checkOutput("areset_read", 64'(instruction_read), 64'd0);
    checkOutput("areset_addr", instruction_address, 64'd0);
    tick();
    reset = 1'b0;
    expect_pc(64'h1000);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("restart_addr", instruction_address, 64'h1000);
    checkOutput("restart_read", 64'(instruction_read), 64'd1);
    tick();
    checkOutput("restart_occ", 64'(occupancy), 64'd1);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("restart_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end placed between the instruction port of the cache and the branch-predict/decode pipeline registers.
- Owns the architectural fetch PC and issues sequential fetch requests to the cache.
- Captures each returned instruction together with its PC in a small FIFO, and hands entries to decode with a valid/ready handshake.
- On a redirect (branch prediction or misprediction), flushes all buffered and in-flight work and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, 2 or larger.
- ADDR_WIDTH, 64, width of PC and fetch address.
- INSN_WIDTH, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- entry  input  ADDR_WIDTH  program entry point; sampled once, after reset.
- instruction_read  output  1  fetch request to the cache.
- instruction_address  output  ADDR_WIDTH  address being fetched; equals the internal pc.
- instruction_busy  input  1  cache is not returning data this cycle.
- instruction_response  input  INSN_WIDTH  instruction data; valid when instruction_read=1 and instruction_busy=0.
- redirect  input  1  overwrite the PC and flush.
- redirect_pc  input  ADDR_WIDTH  new fetch PC.
- out_valid  output  1  head entry is valid.
- out_instruction  output  INSN_WIDTH  head instruction.
- out_pc  output  ADDR_WIDTH  head PC.
- out_ready  input  1  decode accepts the head entry; driven as the inverse of frontend_stall.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- **Reset values:** pc=0, state=IDLE, head=tail=0, count=0, all outputs 0. Reset may assert mid-request; the in-flight fetch is abandoned.
- **FSM states:** IDLE, FETCH, FULL.
- **IDLE:** instruction_read=0. Next edge: pc<=entry, go to FETCH.
- **FETCH:** instruction_read=1, instruction_address=pc.
  - A fetch is accepted when instruction_busy=0 and redirect=0.
  - On acceptance: push {instruction_response, pc} at tail; tail<=(tail+1) mod DEPTH; pc<=pc+4, wrapping modulo 2^ADDR_WIDTH.
  - If the post-update count equals DEPTH, go to FULL.
  - If instruction_busy=1, hold pc and stay in FETCH.
- **FULL:** instruction_read=0, no push. Leave for FETCH on the edge where a pop occurs.
- **Pop:**
  - out_valid = (count!=0) and redirect=0.
  - A pop occurs when out_valid and out_ready: head<=(head+1) mod DEPTH.
  - out_instruction and out_pc always show the head entry, combinationally from the FIFO storage.
- **Count:** push only: +1. Pop only: -1. Push and pop together: unchanged. occupancy=count.
- **Full boundary:**
  - A push never occurs when count==DEPTH; the FSM guarantees this, and an assertion checks it.
  - With count==DEPTH-1, a push with no pop makes the FIFO full.
  - With count==DEPTH-1, a push together with a pop leaves count at DEPTH-1 and stays in FETCH.
- **Empty:** out_valid=0. out_ready is ignored.
- **Redirect (any state except IDLE):** has priority over push and pop. On that edge:
  - head<=0, tail<=0, count<=0.
  - pc<=redirect_pc, state<=FETCH.
  - The cache response of that cycle is discarded.
  - out_valid is forced 0 during the redirect cycle, so no pop is reported.
- **Redirect in IDLE:** ignored; entry is loaded.
- **Back-to-back redirects:** the last one wins; no entries are produced between them.
- **Latency:** the first instruction is visible on out_valid one cycle after the first accepted fetch. Throughput is 1 instruction/cycle while the cache is not busy and decode is ready.
- **Clock gating:** none; no internal multicycle paths.

Test Plan:
- **Reset and stream:** reset, entry=0x1000, cache never busy, out_ready=1 → fetch addresses 0x1000, 0x1004, 0x1008…; out_pc follows the same sequence one cycle later; occupancy stays ≤1.
- **Backpressure and full:** out_ready=0 with DEPTH=4 → after 4 accepted fetches occupancy=4, instruction_read=0, pc=0x1010. Raise out_ready → pops 0x1000..0x100C in order, fetch resumes at 0x1010.
- **Cache busy:** busy=1 for 3 cycles at pc=0x1008 → instruction_address holds 0x1008, no push; busy drops → 0x1008 is pushed exactly once.
- **Redirect with partial FIFO:** occupancy=3, assert redirect with redirect_pc=0x2000, simultaneously busy=0 and out_ready=1 → no pop reported, occupancy=0 next cycle, next fetch at 0x2000, old entries never emerge.
- **Simultaneous push/pop at DEPTH-1:** occupancy=3, push and pop in the same cycle → occupancy stays 3, state FETCH.
- **Async reset mid-stream:** assert reset between edges with occupancy=2 → out_valid=0, occupancy=0 immediately. After release, fetch restarts at entry.
